// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store control stage.
//   - FSM state encodings (IDLE, RD, WR, RESP)
//   - RV64 funct3 size/sign codes
//   - access-size codes (funct3[1:0]) and a lane-mask helper
package lsu_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Byte-lane mask for an access of the given size at offset 0.
    function automatic logic [7:0] size_lanes(input logic [1:0] sz);
        logic [7:0] lanes;
        case (sz)
            SZ_B:    lanes = 8'h01;
            SZ_H:    lanes = 8'h03;
            SZ_W:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: doubleword data_mem bus between lsu_ctrl and data_mem.
//   mem_address    aligned doubleword address (bits [2:0] always zero)
//   mem_write_data write data, committed at posedge while mem_write=1
//   mem_read       combinational read enable
//   mem_write      write enable
//   mem_read_data  read data, valid while mem_read=1
// master: lsu_ctrl side. slave: data_mem side.
interface lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    logic [ADDR_W-1:0] mem_address;
    logic [63:0]       mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [63:0]       mem_read_data;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_read,
        output mem_write,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_read,
        input  mem_write,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane handling for lsu_ctrl.
//   rbuf       in  64  doubleword read from data_mem
//   wdata      in  64  right-justified store data
//   offset     in  3   byte offset within the doubleword (addr[2:0])
//   funct3     in  3   RV64 size/sign code
//   load_data  out 64  addressed bytes, sign- or zero-extended
//   store_data out 64  rbuf with the addressed lanes replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] rbuf,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    function automatic logic [63:0] load_extract(input logic [63:0] dw,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  f3);
        logic [63:0] sh;
        logic [63:0] res;
        sh = dw >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{56{sh[7]}}, sh[7:0]};
            F3_H:    res = {{48{sh[15]}}, sh[15:0]};
            F3_W:    res = {{32{sh[31]}}, sh[31:0]};
            F3_BU:   res = {56'd0, sh[7:0]};
            F3_HU:   res = {48'd0, sh[15:0]};
            F3_WU:   res = {32'd0, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] dw,
                                                input logic [63:0] wd,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  lanes;
        logic [63:0] bit_mask;
        lanes = size_lanes(f3[1:0]) << off;
        for (int k = 0; k < 8; k++) begin
            bit_mask[8*k +: 8] = {8{lanes[k]}};
        end
        // Bytes of wd above the access size fall outside the mask and are dropped.
        return (dw & ~bit_mask) | ((wd << {off, 3'b000}) & bit_mask);
    endfunction

    assign load_data  = load_extract(rbuf, offset, funct3);
    assign store_data = store_merge(rbuf, wdata, offset, funct3);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV64 load/store control stage in front of a doubleword data_mem.
//   clk, reset          clock; synchronous active-high reset
//   req_*               one request per instruction, held stable while stall=1
//   stall               pipeline must not advance
//   load_valid          one-cycle pulse with extended data on load_result
//   fault               one-cycle pulse for a misaligned or illegal request
//   mem                 data_mem bus (lsu_ctrl_if master)
// Sub-doubleword stores do read-modify-write (IDLE, RD, WR, RESP);
// loads go IDLE, RD, RESP; SD goes IDLE, WR, RESP.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [63:0]       load_result,
    output logic              fault,
    lsu_ctrl_if.master        mem
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              is_load_q, is_load_d;
    logic [63:0]       rbuf_q, rbuf_d;

    logic        is_req;
    logic        illegal;
    logic        misaligned;
    logic        accept;
    logic [63:0] load_data;
    logic [63:0] store_data;

    // Request decode; only meaningful while in IDLE.
    always_comb begin
        is_req  = req_valid && (req_load || req_store);
        illegal = (req_load && req_store)
               || (req_load && (req_funct3 == 3'b111))
               || (req_store && req_funct3[2]);
        case (req_funct3[1:0])
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            SZ_D:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        accept = (state_q == StIdle) && is_req && !illegal && !misaligned && !reset;
        fault  = (state_q == StIdle) && is_req && (illegal || misaligned) && !reset;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        is_load_d = is_load_q;
        rbuf_d    = rbuf_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d    = req_addr;
                    funct3_d  = req_funct3;
                    wdata_d   = req_wdata;
                    is_load_d = req_load;
                    // Only a full doubleword store can skip the read.
                    state_d   = (req_load || (req_funct3[1:0] != SZ_D)) ? StRd : StWr;
                end
            end
            StRd: begin
                rbuf_d  = mem.mem_read_data;
                state_d = is_load_q ? StResp : StWr;
            end
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
            is_load_q <= 1'b0;
            rbuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            wdata_q   <= wdata_d;
            is_load_q <= is_load_d;
            rbuf_q    <= rbuf_d;
        end
    end

    lsu_align u_align (
        .rbuf       (rbuf_q),
        .wdata      (wdata_q),
        .offset     (addr_q[2:0]),
        .funct3     (funct3_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Gating by reset keeps a write in flight from committing when reset lands in WR.
    always_comb begin
        stall           = !reset && ((state_q == StRd) || (state_q == StWr) || accept);
        mem.mem_read    = !reset && (state_q == StRd);
        mem.mem_write   = !reset && (state_q == StWr);
        mem.mem_address = (!reset && (state_q != StIdle)) ? {addr_q[ADDR_W-1:3], 3'b000}
                                                          : '0;
        mem.mem_write_data = '0;
        if (mem.mem_write) begin
            mem.mem_write_data = (funct3_q[1:0] == SZ_D) ? wdata_q : store_data;
        end
        load_valid  = !reset && (state_q == StResp) && is_load_q;
        load_result = load_valid ? load_data : '0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a small doubleword memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        stall, load_valid, fault;
    logic [63:0] load_result;

    int n_checks = 0;
    int n_errors = 0;

    lsu_ctrl_if #(.ADDR_W(64)) mif ();

    lsu_ctrl #(.ADDR_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_load    (req_load),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .load_valid  (load_valid),
        .load_result (load_result),
        .fault       (fault),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    // Eight doublewords covering 0x100..0x13F via address bits [5:3].
    logic [63:0] mem_model [0:7];
    assign mif.mem_read_data = mif.mem_read ? mem_model[mif.mem_address[5:3]] : 64'd0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem_model[i] <= 64'd0;
        end else if (mif.mem_write) begin
            mem_model[mif.mem_address[5:3]] <= mif.mem_write_data;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
    endtask

    // Runs one legal request to completion; samples 1 time unit after each negedge.
    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] res, output logic lv, output int ncyc,
                          output int nstall, output int nwr, output int nrd,
                          output logic [63:0] waddr);
        bit done;
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        ncyc = 0; nstall = 0; nwr = 0; nrd = 0; waddr = 64'hDEAD; res = 64'hDEAD;
        lv = 1'b0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            ncyc++;
            if (stall) nstall++;
            if (mif.mem_read) nrd++;
            if (mif.mem_write) begin
                nwr++;
                waddr = mif.mem_address;
            end
            if (!stall) begin
                done = 1;
                res = load_result;
                lv = load_valid;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check_eq("req_timeout", 64'd0, 64'd1);
        idle_inputs();
    endtask

    task automatic do_bad(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [63:0] addr);
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = 64'h5555;
        #1;
        check_eq({tag, "_fault"}, {63'd0, fault}, 64'd1);
        check_eq({tag, "_stall"}, {63'd0, stall}, 64'd0);
        check_eq({tag, "_memrw"}, {62'd0, mif.mem_read, mif.mem_write}, 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq({tag, "_fault_pulse"}, {63'd0, fault}, 64'd0);
        check_eq({tag, "_still_idle"}, mif.mem_address | {63'd0, stall}, 64'd0);
    endtask

    logic [63:0] res, waddr;
    logic        lv;
    int          ncyc, nstall, nwr, nrd;

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_outputs", {60'd0, stall, load_valid, fault, mif.mem_read}, 64'd0);
        check_eq("reset_memw", {63'd0, mif.mem_write}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: SD then LD
        do_req(1'b0, 1'b1, F3_D, 64'h100, 64'h1122334455667788, res, lv, ncyc, nstall, nwr, nrd,
               waddr);
        check_eq("sd_cycles", ncyc, 3);
        check_eq("sd_stall", nstall, 2);
        check_eq("sd_writes", nwr, 1);
        check_eq("sd_reads", nrd, 0);
        check_eq("sd_waddr", waddr, 64'h100);
        check_eq("sd_no_lv", {63'd0, lv}, 64'd0);
        do_req(1'b1, 1'b0, F3_D, 64'h100, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("ld_cycles", ncyc, 3);
        check_eq("ld_stall", nstall, 2);
        check_eq("ld_lv", {63'd0, lv}, 64'd1);
        check_eq("ld_data", res, 64'h1122334455667788);
        check_eq("ld_writes", nwr, 0);

        // 2: SB then LB / LBU
        do_req(1'b0, 1'b1, F3_B, 64'h103, 64'h00000000000000AB, res, lv, ncyc, nstall, nwr,
               nrd, waddr);
        check_eq("sb_cycles", ncyc, 4);
        check_eq("sb_stall", nstall, 3);
        check_eq("sb_rw", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
        check_eq("sb_mem", mem_model[0], 64'h11223344AB667788);
        do_req(1'b1, 1'b0, F3_B, 64'h103, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("lb_data", res, 64'hFFFFFFFFFFFFFFAB);
        do_req(1'b1, 1'b0, F3_BU, 64'h103, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("lbu_data", res, 64'h00000000000000AB);

        // 3: SH then LH / LW / LWU
        do_req(1'b0, 1'b1, F3_H, 64'h106, 64'hFFFF_0000_1234_BEEF, res, lv, ncyc, nstall, nwr,
               nrd, waddr);
        check_eq("sh_cycles", ncyc, 4);
        check_eq("sh_mem", mem_model[0], 64'hBEEF3344AB667788);
        do_req(1'b1, 1'b0, F3_H, 64'h106, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("lh_data", res, 64'hFFFFFFFFFFFFBEEF);
        do_req(1'b1, 1'b0, F3_W, 64'h104, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("lw_data", res, 64'hFFFFFFFFBEEF3344);
        do_req(1'b1, 1'b0, F3_WU, 64'h104, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("lwu_data", res, 64'h00000000BEEF3344);
        do_req(1'b1, 1'b0, F3_HU, 64'h100, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("lhu_data", res, 64'h0000000000007788);

        // 4: faults
        do_bad("lw_mis", 1'b1, 1'b0, F3_W, 64'h102);
        do_bad("sd_mis", 1'b0, 1'b1, F3_D, 64'h10C);
        do_bad("ld_f3_7", 1'b1, 1'b0, 3'b111, 64'h100);
        do_bad("st_f3_4", 1'b0, 1'b1, 3'b100, 64'h100);

        // 5: SW with reset asserted during WR
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W;
        req_addr = 64'h108; req_wdata = 64'hCAFEBABE;
        #1;
        check_eq("sw_accept_stall", {63'd0, stall}, 64'd1);
        @(negedge clk);
        #1;
        check_eq("sw_rd", {62'd0, mif.mem_read, mif.mem_write}, 64'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("sw_rst_memw", {63'd0, mif.mem_write}, 64'd0);
        check_eq("sw_rst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check_eq("sw_rst_idle", mif.mem_address | {63'd0, stall}, 64'd0);
        do_req(1'b1, 1'b0, F3_D, 64'h108, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("ld_after_rst", res, 64'd0);

        // 6: load and store both set, then a clean LD
        do_req(1'b0, 1'b1, F3_D, 64'h100, 64'h0102030405060708, res, lv, ncyc, nstall, nwr,
               nrd, waddr);
        do_bad("ldst", 1'b1, 1'b1, F3_D, 64'h100);
        do_req(1'b1, 1'b0, F3_D, 64'h100, 64'd0, res, lv, ncyc, nstall, nwr, nrd, waddr);
        check_eq("ldst_next_cycles", ncyc, 3);
        check_eq("ldst_next_data", res, 64'h0102030405060708);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage sitting directly upstream of data_mem; receives one memory request per instruction from the EX/MEM pipeline stage.
- Converts RV64 byte/half/word/doubleword loads and stores into data_mem's doubleword-wide interface.
- Sub-doubleword stores use read-modify-write; loads are sign- or zero-extended.
- Holds the pipeline with stall while a request is in flight.

Parameters:
- ADDR_W, 64, request and data_mem address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present; held stable by the pipeline while stall=1.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_funct3  in  3  RV64 size/sign code.
  - Loads: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
  - Stores: SB 000, SH 001, SW 010, SD 011.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, right-justified.
- stall  out  1  pipeline must not advance.
- load_valid  out  1  load_result valid, one-cycle pulse.
- load_result  out  64  extended load data.
- fault  out  1  one-cycle pulse for a misaligned or illegal request.
- mem_address  out  ADDR_W  to data_mem.address.
- mem_write_data  out  64  to data_mem.write_data.
- mem_read  out  1  to data_mem.MemRead.
- mem_write  out  1  to data_mem.MemWrite.
- mem_read_data  in  64  from data_mem.read_data.

Behaviour:
- data_mem contract:
  - Read is combinational while mem_read=1.
  - Write commits at posedge while mem_write=1.
  - mem_address is always the 8-byte-aligned address: req_addr with bits [2:0] cleared.
- Little-endian: byte k of a doubleword occupies bits [8k+7:8k]. Lane offset is addr[2:0].
- Legality:
  - Illegal: load with funct3=111, store with funct3[2]=1, or req_load and req_store both set.
  - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Response: fault=1 in the same cycle, combinational from IDLE. No stall, no memory access, no state change. The request is dropped.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE: on req_valid with a legal request, latch addr, funct3, wdata and op at the posedge; stall=1 combinationally.
    - Load or SB/SH/SW → RD.
    - SD → WR.
  - RD: mem_read=1; capture mem_read_data into rbuf at the posedge.
    - Load → RESP.
    - Partial store → WR.
  - WR: mem_write=1.
    - mem_write_data is the latched wdata for SD.
    - For partial stores, it is rbuf with the addressed lanes replaced by the low 1/2/4 bytes of wdata.
    - Next state → RESP.
  - RESP: stall=0, so the pipeline advances at this edge. For loads, load_valid=1 and load_result is the extracted and extended value from rbuf. Next state → IDLE unconditionally; a new request is not accepted in RESP.
  - stall = (state≠IDLE && state≠RESP) || (state==IDLE && req_valid && legal).
- Latency, counted in cycles including the accept cycle:
  - Load: 3 (IDLE, RD, RESP).
  - SD: 3 (IDLE, WR, RESP).
  - SB/SH/SW: 4 (IDLE, RD, WR, RESP).
- Values outside RESP:
  - load_result holds 0.
  - mem_write_data is 0 when mem_write=0.
  - mem_address is 0 in IDLE.
- Reset:
  - Next state is IDLE; rbuf and all latches are cleared.
  - All outputs are 0 during and after reset.
  - mem_read and mem_write are gated by ~reset, so a reset asserted during WR suppresses the write.
- A request arriving in RESP is ignored until IDLE; the pipeline guarantees a new request only appears after advancing.

Decomposition:
- lsu_pkg holds:
  - State enum {IDLE, RD, WR, RESP}.
  - funct3 constants F3_B/H/W/D/BU/HU/WU.
  - Size-decode helper constants.
- One combinational sub-module, lsu_align, with two functions:
  - Load path: extract plus sign/zero-extend (inputs rbuf, addr[2:0], funct3).
  - Store path: lane merge (inputs rbuf, wdata, addr[2:0], funct3).
- FSM, latches and stall logic stay in lsu_ctrl.

Test Plan:
1. SD 0x100 with 0x1122334455667788, then LD 0x100 → stall high 2 cycles per request; load_valid in the 3rd cycle with 0x1122334455667788; the SD asserts mem_write exactly once, with mem_address=0x100.
2. SB 0x103 with 0xAB → RD then WR; memory becomes 0x11223344AB667788. LB 0x103 → 0xFFFFFFFFFFFFFFAB; LBU 0x103 → 0x00000000000000AB.
3. SH 0x106 with 0xBEEF → memory becomes 0xBEEF3344AB667788. LH 0x106 → 0xFFFFFFFFFFFFBEEF; LW 0x104 → 0xFFFFFFFFBEEF3344; LWU 0x104 → 0x00000000BEEF3344.
4. LW 0x102, SD 0x10C, and a load with funct3=111 → fault one cycle each; stall=0, mem_read=mem_write=0, state stays IDLE.
5. SW 0x108 with 0xCAFEBABE, reset asserted during the WR cycle → mem_write=0 that cycle; state IDLE next; LD 0x108 then returns the old contents.
6. req_load=req_store=1 at 0x100 → fault=1, no memory access; the next legal LD 0x100 completes normally in 3 cycles.
